fir_apb_master: RTL and testbench

APB initiator that drives the FIR accelerator's register slave so the accelerator can run without CPU involvement. It accepts raw sensor samples on a valid/ready stream and, for each sample, writes DATA_IN, polls STATUS until the valid bit is set, and reads RESULT. The filtered result is returned on a valid/ready output stream. It sits between the sensor front-end and the accelerator's APB port, and performs the CONTROL register setup itself.

---
 rtl/fir_apb_master_if.sv | 24 ++
 rtl/fir_apb_master.sv | 163 ++++++++++++++++
 tb/tb_fir_apb_master.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_apb_master_if.sv
// APB bundle between fir_apb_master (initiator) and the FIR accelerator's register slave.
interface fir_apb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pready_i;
  logic                  pslverr_i;

  modport master (
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport slave (
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o,
    output prdata_i, pready_i, pslverr_i
  );
endinterface

// File: rtl/fir_apb_master.sv
// Sequences the FIR accelerator over APB: CONTROL setup, then per sample DATA_IN write,
// STATUS polling and RESULT read, returning the result on a valid/ready stream.
//
// state     | meaning
// S_IDLE    | no transfer; picks clear, setup or a new sample
// S_CTRL_WR | write CTRL_VALUE to CONTROL, then mark setup done
// S_CLR_WR  | write CTRL_VALUE|0x4 to CONTROL (coefficient clear), then S_CTRL_WR
// S_DATA_WR | write the latched sample to DATA_IN
// S_STAT_RD | read STATUS until bit 0 is set or the poll budget runs out
// S_RES_RD  | read RESULT into the output register
module fir_apb_master #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] CTRL_VALUE = 32'h0000_0009,
  parameter int                    POLL_LIMIT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
  output logic                  sample_ready_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  error_o,
  fir_apb_master_if.master      apb
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CTRL_WR = 3'd1;
  localparam logic [2:0] S_CLR_WR  = 3'd2;
  localparam logic [2:0] S_DATA_WR = 3'd3;
  localparam logic [2:0] S_STAT_RD = 3'd4;
  localparam logic [2:0] S_RES_RD  = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] OFF_CTRL = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] OFF_STAT = ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] OFF_DATA = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] OFF_RES  = ADDR_WIDTH'(32'h10);
  localparam logic [DATA_WIDTH-1:0] CLR_BIT  = DATA_WIDTH'(32'h04);

  localparam int PCW = $clog2(POLL_LIMIT + 1);

  logic [2:0]            state;
  logic                  accessPh;
  logic                  ctrlDone;
  logic                  clrPending;
  logic [DATA_WIDTH-1:0] sampleReg;
  logic [DATA_WIDTH-1:0] resultReg;
  logic                  resultValid;
  logic                  errorReg;
  logic [PCW-1:0]        pollLeft;
  logic                  clearReq;
  logic                  sampleFire;

  // A pending clear also blocks sample acceptance so IDLE never commits to both.
  assign clearReq       = clrPending | clear_i;
  assign sample_ready_o = (state == S_IDLE) & ctrlDone & ~resultValid & ~clearReq;
  assign sampleFire     = sample_ready_o & sample_valid_i;

  assign busy_o         = (state != S_IDLE);
  assign error_o        = errorReg;
  assign result_o       = resultReg;
  assign result_valid_o = resultValid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      accessPh    <= 1'b0;
      ctrlDone    <= 1'b0;
      clrPending  <= 1'b0;
      sampleReg   <= '0;
      resultReg   <= '0;
      resultValid <= 1'b0;
      errorReg    <= 1'b0;
      pollLeft    <= '0;
    end else begin
      if (result_ready_i) resultValid <= 1'b0;
      if (clear_i) clrPending <= 1'b1;

      if (state == S_IDLE) begin
        if (clearReq) begin
          state      <= S_CLR_WR;
          clrPending <= 1'b0;
          errorReg   <= 1'b0;
        end else if (!ctrlDone) begin
          state <= S_CTRL_WR;
        end else if (sampleFire) begin
          sampleReg <= sample_i;
          state     <= S_DATA_WR;
        end
      end else if (!accessPh) begin
        accessPh <= 1'b1;
      end else if (apb.pready_i) begin
        accessPh <= 1'b0;
        if (apb.pslverr_i) begin
          errorReg <= 1'b1;
          state    <= S_IDLE;
        end else begin
          case (state)
            S_CTRL_WR: begin
              ctrlDone <= 1'b1;
              state    <= S_IDLE;
            end
            S_CLR_WR: state <= S_CTRL_WR;
            S_DATA_WR: begin
              pollLeft <= PCW'(POLL_LIMIT);
              state    <= S_STAT_RD;
            end
            S_STAT_RD: begin
              if (apb.prdata_i[0]) begin
                state <= S_RES_RD;
              end else if (pollLeft == PCW'(1)) begin
                errorReg <= 1'b1;
                state    <= S_IDLE;
              end else begin
                pollLeft <= pollLeft - PCW'(1);
              end
            end
            S_RES_RD: begin
              resultReg   <= apb.prdata_i;
              resultValid <= 1'b1;
              state       <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    apb.psel_o    = (state != S_IDLE);
    apb.penable_o = accessPh;
    apb.pwrite_o  = 1'b0;
    apb.paddr_o   = '0;
    apb.pwdata_o  = '0;
    case (state)
      S_CTRL_WR: begin
        apb.pwrite_o = 1'b1;
        apb.paddr_o  = BASE_ADDR + OFF_CTRL;
        apb.pwdata_o = CTRL_VALUE;
      end
      S_CLR_WR: begin
        apb.pwrite_o = 1'b1;
        apb.paddr_o  = BASE_ADDR + OFF_CTRL;
        apb.pwdata_o = CTRL_VALUE | CLR_BIT;
      end
      S_DATA_WR: begin
        apb.pwrite_o = 1'b1;
        apb.paddr_o  = BASE_ADDR + OFF_DATA;
        apb.pwdata_o = sampleReg;
      end
      S_STAT_RD: apb.paddr_o = BASE_ADDR + OFF_STAT;
      S_RES_RD:  apb.paddr_o = BASE_ADDR + OFF_RES;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_apb_master.sv
// Bench for fir_apb_master: a behavioural accelerator slave on APB, randomized samples and
// a result scoreboard checked by an independent monitor.
module tb_fir_apb_master;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] sample_i = '0;
  logic        sample_valid_i = 1'b0;
  logic        sample_ready_o;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic        result_ready_i;
  logic        clear_i = 1'b0;
  logic        busy_o;
  logic        error_o;

  logic randReady = 1'b0;
  logic readyRand = 1'b0;
  logic readyDir  = 1'b1;
  assign result_ready_i = randReady ? readyRand : readyDir;

  fir_apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

  fir_apb_master dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .clear_i        (clear_i),
    .busy_o         (busy_o),
    .error_o        (error_o),
    .apb            (apb)
  );

  always #5 clk_i = ~clk_i;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          penCycles;
    logic        errAtSetup;
  } xfer_t;
  xfer_t xlog[$];
  logic [31:0] expQ[$];

  // Slave configuration, set by the stimulus before each sample.
  int          cfgNotReady = 0;
  int          cfgWaitData = 0;
  int          cfgWaitAll  = 0;
  logic        errArmed = 1'b0;
  logic [31:0] errAddr  = '0;

  function automatic logic [31:0] accelFn(input logic [31:0] x);
    return x ^ 32'h0000_B9F9;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int statusReads();
    int c = 0;
    foreach (xlog[i]) if (!xlog[i].wr && xlog[i].addr == 32'h4) c++;
    return c;
  endfunction

  // Behavioural accelerator register slave.
  initial begin
    logic [31:0] sAddr, sData, lastRes;
    logic        sWr, sErr;
    int          waitLeft, pen, notReadyLeft;
    lastRes = '0; notReadyLeft = 0; waitLeft = 0; pen = 0;
    sAddr = '0; sData = '0; sWr = 1'b0; sErr = 1'b0;
    apb.prdata_i = '0; apb.pready_i = 1'b0; apb.pslverr_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      apb.pready_i = 1'b0; apb.pslverr_i = 1'b0; apb.prdata_i = '0;
      if (rst_i) continue;
      if (apb.psel_o && !apb.penable_o) begin
        sAddr = apb.paddr_o; sData = apb.pwdata_o; sWr = apb.pwrite_o; sErr = error_o;
        waitLeft = (apb.paddr_o == 32'h8) ? cfgWaitData : cfgWaitAll;
        pen = 0;
      end else if (apb.psel_o && apb.penable_o) begin
        pen++;
        check("apb_stable", {apb.paddr_o, apb.pwdata_o}, {sAddr, sData});
        if (waitLeft > 0) begin
          waitLeft--;
        end else begin
          xfer_t t;
          apb.pready_i = 1'b1;
          if (sWr) begin
            if (sAddr == 32'h8) begin
              lastRes = accelFn(sData);
              notReadyLeft = cfgNotReady;
            end
            t.data = sData;
          end else begin
            if (sAddr == 32'h4) begin
              if (notReadyLeft > 0) begin
                apb.prdata_i = 32'h0;
                notReadyLeft--;
              end else apb.prdata_i = 32'h1;
            end else if (sAddr == 32'h10) apb.prdata_i = lastRes;
            t.data = apb.prdata_i;
          end
          if (errArmed && sAddr == errAddr) begin
            apb.pslverr_i = 1'b1;
            errArmed = 1'b0;
          end
          t.wr = sWr; t.addr = sAddr; t.penCycles = pen; t.errAtSetup = sErr;
          xlog.push_back(t);
        end
      end
    end
  end

  // Scoreboard monitor: compares every result handshake against the expected queue.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && result_valid_o && result_ready_i) begin
        nChecks++;
        if (expQ.size() == 0) begin
          nErrors++;
          $display("FAIL result_unexpected: got=%0h expected=none", result_o);
        end else begin
          logic [31:0] e;
          e = expQ.pop_front();
          if (result_o !== e) begin
            nErrors++;
            $display("FAIL result_value: got=%0h expected=%0h", result_o, e);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i); #1;
      readyRand = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin @(posedge clk_i); #1; n++; end
    if (busy_o) begin
      nChecks++; nErrors++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic waitLog(input int cnt, input int budget);
    int n = 0;
    while (xlog.size() < cnt && n < budget) begin @(posedge clk_i); #1; n++; end
    if (xlog.size() < cnt) begin
      nChecks++; nErrors++;
      $display("FAIL wait_xfer: got %0d transfers, expected %0d", xlog.size(), cnt);
    end
  endtask

  task automatic waitValid(input int budget);
    int n = 0;
    while (!result_valid_o && n < budget) begin @(posedge clk_i); #1; n++; end
    if (!result_valid_o) begin
      nChecks++; nErrors++;
      $display("FAIL wait_valid: result_valid=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin @(posedge clk_i); #1; n++; end
    check("scoreboard_drained", 64'(expQ.size()), 64'd0);
  endtask

  task automatic sendSample(input logic [31:0] s, input bit expectRes);
    int n = 0;
    sample_i = s;
    sample_valid_i = 1'b1;
    while (!sample_ready_o && n < 500) begin @(posedge clk_i); #1; n++; end
    if (!sample_ready_o) begin
      nChecks++; nErrors++;
      $display("FAIL sample_accept: ready=0 after %0d cycles, expected 1", n);
      sample_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    if (expectRes) expQ.push_back(accelFn(s));
    #1;
    sample_valid_i = 1'b0;
  endtask

  task automatic doClear();
    xlog.delete();
    clear_i = 1'b1;
    #1;
    check("clear_blocks_ready", 64'(sample_ready_o), 64'd0);
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    waitLog(2, 50);
    waitIdle(50);
    if (xlog.size() >= 2) begin
      check("clr_write", {xlog[0].wr, xlog[0].addr, xlog[0].data}, {1'b1, 32'h0, 32'hD});
      check("clr_err_at_start", 64'(xlog[0].errAtSetup), 64'd0);
      check("ctrl_rewrite", {xlog[1].wr, xlog[1].addr, xlog[1].data}, {1'b1, 32'h0, 32'h9});
    end
    check("error_after_clear", 64'(error_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic errModel;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outputs",
          {sample_ready_o, result_valid_o, result_o, busy_o, error_o,
           apb.psel_o, apb.penable_o, apb.pwrite_o, apb.paddr_o[15:0]}, 64'd0);
    check("reset_pwdata", 64'(apb.pwdata_o), 64'd0);
    rst_i = 1'b0;

    // Setup write after reset.
    waitLog(1, 20);
    if (xlog.size() >= 1)
      check("init_ctrl", {xlog[0].wr, xlog[0].addr, xlog[0].data}, {1'b1, 32'h0, 32'h9});
    begin
      int n = 0;
      while (!sample_ready_o && n < 20) begin @(posedge clk_i); #1; n++; end
    end
    check("init_idle_ready", {busy_o, sample_ready_o}, 2'b01);

    // Zero-wait latency.
    xlog.delete();
    sendSample(32'h1234, 1'b1);
    lat = 0;
    while (!result_valid_o && lat < 50) begin @(posedge clk_i); #1; lat++; end
    check("latency_edges", 64'(lat), 64'd6);
    check("latency_result", 64'(result_o), 64'hABCD);
    waitIdle(20);
    check("seq_len", 64'(xlog.size()), 64'd3);
    if (xlog.size() == 3) begin
      check("seq_data_wr", {xlog[0].wr, xlog[0].addr, xlog[0].data}, {1'b1, 32'h8, 32'h1234});
      check("seq_stat_rd", {xlog[1].wr, xlog[1].addr}, {1'b0, 32'h4});
      check("seq_res_rd", {xlog[2].wr, xlog[2].addr}, {1'b0, 32'h10});
    end
    waitDrain(20);

    // Wait states on DATA_WR.
    @(posedge clk_i); #1;
    xlog.delete();
    cfgWaitData = 3;
    sendSample(32'h1234, 1'b1);
    waitIdle(50);
    cfgWaitData = 0;
    if (xlog.size() >= 1) begin
      check("wait_penable_cycles", 64'(xlog[0].penCycles), 64'd4);
      check("wait_data_wr", {xlog[0].addr, xlog[0].data}, {32'h8, 32'h1234});
    end
    check("wait_stat_reads", 64'(statusReads()), 64'd1);
    waitDrain(20);

    // Slave error on DATA_WR, then clear.
    @(posedge clk_i); #1;
    xlog.delete();
    errArmed = 1'b1; errAddr = 32'h8;
    sendSample(32'h5555, 1'b0);
    waitIdle(50);
    check("slverr_error", 64'(error_o), 64'd1);
    check("slverr_no_poll", 64'(xlog.size()), 64'd1);
    @(posedge clk_i); #1;
    doClear();

    // Poll timeout.
    @(posedge clk_i); #1;
    xlog.delete();
    cfgNotReady = 100;
    sendSample(32'h77, 1'b0);
    waitIdle(300);
    cfgNotReady = 0;
    check("timeout_reads", 64'(statusReads()), 64'd16);
    check("timeout_error", {error_o, result_valid_o}, 2'b10);
    @(posedge clk_i); #1;
    check("timeout_ready_after", 64'(sample_ready_o), 64'd1);
    doClear();

    // Result backpressure.
    @(posedge clk_i); #1;
    readyDir = 1'b0;
    sendSample(32'h2222, 1'b1);
    waitValid(50);
    sample_i = 32'h3333;
    sample_valid_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      check("bp_hold", {sample_ready_o, result_valid_o, result_o}, {2'b01, accelFn(32'h2222)});
    end
    readyDir = 1'b1;
    @(posedge clk_i); #1;
    readyDir = 1'b0;
    check("bp_release", {result_valid_o, sample_ready_o}, 2'b01);
    sendSample(32'h3333, 1'b1);
    readyDir = 1'b1;
    waitIdle(50);
    waitDrain(50);

    // Randomized traffic against the reference rules.
    randReady = 1'b1;
    errModel  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int  nr, pick, expReads;
      bit  inj, expRes;
      logic [31:0] s;
      nr   = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      inj  = ($urandom_range(0, 9) == 0);
      pick = int'($urandom_range(0, 2));
      errAddr = (pick == 0) ? 32'h8 : (pick == 1) ? 32'h4 : 32'h10;
      if (nr >= 16 && errAddr == 32'h10) errAddr = 32'h4;
      cfgNotReady = nr;
      cfgWaitData = int'($urandom_range(0, 2));
      cfgWaitAll  = int'($urandom_range(0, 2));
      errArmed    = inj;
      expRes      = !inj && nr < 16;
      if (inj) expReads = (errAddr == 32'h8) ? 0 : (errAddr == 32'h4) ? 1 : nr + 1;
      else     expReads = (nr + 1 < 16) ? nr + 1 : 16;
      errModel = errModel | !expRes;
      s = $urandom;
      xlog.delete();
      sendSample(s, expRes);
      waitIdle(400);
      check("rand_stat_reads", 64'(statusReads()), 64'(expReads));
      check("rand_error", 64'(error_o), 64'(errModel));
      if ($urandom_range(0, 5) == 0) begin
        doClear();
        errModel = 1'b0;
      end
    end
    errArmed = 1'b0;
    cfgWaitData = 0; cfgWaitAll = 0; cfgNotReady = 0;
    waitDrain(200);
    randReady = 1'b0;
    readyDir  = 1'b1;

    // Reset in the middle of a transfer.
    @(posedge clk_i); #1;
    sendSample(32'h99, 1'b0);
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    #1;
    check("mid_reset_bus", {apb.psel_o, apb.penable_o, busy_o, sample_ready_o}, 4'b0000);
    repeat (2) @(posedge clk_i);
    #2;
    xlog.delete();
    rst_i = 1'b0;
    waitLog(1, 20);
    if (xlog.size() >= 1)
      check("post_reset_ctrl", {xlog[0].wr, xlog[0].addr, xlog[0].data}, {1'b1, 32'h0, 32'h9});
    waitIdle(20);
    repeat (3) @(posedge clk_i);
    check("final_no_result", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
